// File: rtl/mem_bist_ctrl.sv
// rtl/mem_bist_ctrl.sv - built-in self-test sequencer for a simple dual-port block RAM
//
// Writes a selected pattern to every RAM address through port A, reads every address
// back through port B, and compares the read data against the expected pattern.
// While busy, the sequencer owns both RAM ports.
//
// Optional build macro: MEM_BIST_INV_PASS_EN
//   Adds a second write/read/drain pass that uses the inverted pattern.
//   Errors from both passes accumulate.
//
// Parameters:
//   ADDR_W  RAM address width (DEPTH = 2**ADDR_W)
//   DATA_W  RAM data width
//   RD_LAT  port-B read latency in clocks, addrb -> doutb (1..4)
//
// Ports:
//   clk40m          in   system clock
//   RST             in   asynchronous active-high reset
//   start           in   one-cycle pulse that begins a test; ignored while busy
//   pattern_sel     in   0:{~addr,addr} 1:checkerboard 2:all-0 3:all-1
//   busy            out  test in progress
//   done            out  test complete; cleared by the next accepted start
//   pass            out  valid while done; 1 = no mismatches
//   err_count       out  mismatch count, saturating at 8'hFF
//   first_err_addr  out  address of the first mismatch, or 0 if there was none
//   wea/addra/dina  out  RAM port A (write)
//   addrb           out  RAM port B address
//   doutb           in   RAM port B read data
module mem_bist_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk40m,
    input  logic              RST,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state;
    logic [1:0]  sel_q;
    logic        inv_q;
    logic [2:0]  drain_cnt;

    // Compare pipeline. Stage 0 is loaded in the same edge that drives addrb.
    // Stage RD_LAT lines up with doutb for that address.
    logic [RD_LAT:0]   pv;
    logic [DATA_W-1:0] pe [RD_LAT+1];
    logic [ADDR_W-1:0] pa [RD_LAT+1];
    logic              mismatch;

    assign mismatch = pv[RD_LAT] && (doutb != pe[RD_LAT]);

    function automatic logic [DATA_W-1:0] pat(
        input logic [ADDR_W-1:0] a,
        input logic [1:0]        sel,
        input logic              inv
    );
        logic [2*ADDR_W+DATA_W-1:0] ext;
        logic [DATA_W-1:0]          p;
        p   = '0;
        // Zero padding on the MSB side covers DATA_W > 2*ADDR_W.
        // Slicing covers the truncation case.
        ext = {{DATA_W{1'b0}}, ~a, a};
        case (sel)
            2'd0:    p = ext[DATA_W-1:0];
            2'd1:    for (int i = 0; i < DATA_W; i++) p[i] = a[0] ^ i[0];
            2'd2:    p = '0;
            default: p = '1;
        endcase
        return inv ? ~p : p;
    endfunction

    always_ff @(posedge clk40m or posedge RST) begin
        if (RST) begin
            state          <= S_IDLE;
            sel_q          <= 2'd0;
            inv_q          <= 1'b0;
            drain_cnt      <= 3'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 8'd0;
            first_err_addr <= '0;
            wea            <= 1'b0;
            addra          <= '0;
            dina           <= '0;
            addrb          <= '0;
            pv             <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                pe[i] <= '0;
                pa[i] <= '0;
            end
        end else begin
            pv <= {pv[RD_LAT-1:0], 1'b0};
            for (int i = 1; i <= RD_LAT; i++) begin
                pe[i] <= pe[i-1];
                pa[i] <= pa[i-1];
            end

            if (mismatch) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                if (err_count == 8'd0)  first_err_addr <= pa[RD_LAT];
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_WRITE;
                        sel_q          <= pattern_sel;
                        inv_q          <= 1'b0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= 8'd0;
                        first_err_addr <= '0;
                        wea            <= 1'b1;
                        addra          <= '0;
                        dina           <= pat('0, pattern_sel, 1'b0);
                    end
                end

                S_WRITE: begin
                    if (addra == ADDR_MAX) begin
                        // Last write is on the bus now. Hand over to the read side
                        // without issuing any extra write.
                        state  <= S_READ;
                        wea    <= 1'b0;
                        addra  <= '0;
                        addrb  <= '0;
                        pv[0]  <= 1'b1;
                        pe[0]  <= pat('0, sel_q, inv_q);
                        pa[0]  <= '0;
                    end else begin
                        addra  <= addra + 1'b1;
                        dina   <= pat(addra + 1'b1, sel_q, inv_q);
                    end
                end

                S_READ: begin
                    if (addrb == ADDR_MAX) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 3'd0;
                    end else begin
                        addrb  <= addrb + 1'b1;
                        pv[0]  <= 1'b1;
                        pe[0]  <= pat(addrb + 1'b1, sel_q, inv_q);
                        pa[0]  <= addrb + 1'b1;
                    end
                end

                S_DRAIN: begin
                    drain_cnt <= drain_cnt + 3'd1;
`ifdef MEM_BIST_INV_PASS_EN
                    // The second pass may start while the last first-pass compares
                    // are still in the pipeline. Those compares are unaffected.
                    if (!inv_q && drain_cnt == 3'(RD_LAT - 1)) begin
                        state <= S_WRITE;
                        inv_q <= 1'b1;
                        wea   <= 1'b1;
                        addra <= '0;
                        dina  <= pat('0, sel_q, 1'b1);
                    end else if (drain_cnt == 3'(RD_LAT)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == 8'd0);
                    end
`else
                    // The final compare has updated err_count on the previous edge.
                    if (drain_cnt == 3'(RD_LAT)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == 8'd0);
                    end
`endif
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
